// File: rtl/m32_8_pkg.sv
// Shared PHY constants for the 32->8 serializer and its 8->32 partner.
// M32_8_IDLE_COM_EN selects the idle byte driven between words (COM or zero).
package m32_8_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = 2;
  localparam int unsigned SHIFT_W        = WORD_W - BYTE_W;

  localparam logic [BYTE_W-1:0] COM = 8'hBC;

`ifdef M32_8_IDLE_COM_EN
  localparam logic [BYTE_W-1:0] IDLE_BYTE = COM;
`else
  localparam logic [BYTE_W-1:0] IDLE_BYTE = 8'h00;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/m32_8.sv
// 32-bit word to byte serializer, MSB byte first, one byte per clk_4f edge.
// Idle byte between words is chosen by M32_8_IDLE_COM_EN (see m32_8_pkg).
module m32_8
  import m32_8_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_input,
  input  logic              valid_input,
  output logic              ready_out,
  output logic [BYTE_W-1:0] data_32_8,
  output logic              valid_32_8,
  output logic              sincout
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SHIFT_W-1:0] r_shift;
  logic [BYTE_W-1:0]  r_data;
  logic               r_valid;
  logic               r_sinc;

  logic               w_ready;
  logic               w_xfer;

  // Accept a new word when idle or on the last byte of the current one.
  assign w_ready = ((r_state == IDLE) || (r_cnt == '0)) && !reset;
  assign w_xfer  = valid_input && w_ready;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sinc  <= 1'b0;
    end else if (w_xfer) begin
      r_state <= SEND;
      r_cnt   <= CNT_W'(BYTES_PER_WORD - 1);
      r_shift <= data_input[SHIFT_W-1:0];
      r_data  <= data_input[WORD_W-1 -: BYTE_W];
      r_valid <= 1'b1;
      r_sinc  <= 1'b1;
    end else begin
      case (r_state)
        SEND: begin
          if (r_cnt != '0) begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_data  <= r_shift[SHIFT_W-1 -: BYTE_W];
            r_shift <= {r_shift[SHIFT_W-BYTE_W-1:0], BYTE_W'(0)};
            r_valid <= 1'b1;
            r_sinc  <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_data  <= IDLE_BYTE;
            r_valid <= 1'b0;
            r_sinc  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_data  <= IDLE_BYTE;
          r_valid <= 1'b0;
          r_sinc  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out  = w_ready;
  assign data_32_8  = r_data;
  assign valid_32_8 = r_valid;
  assign sincout    = r_sinc;

endmodule

// File: tb/tb_m32_8.sv
// Scoreboard bench for m32_8: a cycle model pushes expected bytes/words on each
// accepted transfer; the negedge monitor pops and compares DUT output.
module tb_m32_8;

`ifdef M32_8_IDLE_COM_EN
  localparam logic [7:0] TB_IDLE = 8'hBC;
`else
  localparam logic [7:0] TB_IDLE = 8'h00;
`endif

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] data_input;
  logic        valid_input;
  logic        ready_out;
  logic [7:0]  data_32_8;
  logic        valid_32_8;
  logic        sincout;

  always #5 clk_4f = ~clk_4f;

  m32_8 dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .data_input  (data_input),
    .valid_input (valid_input),
    .ready_out   (ready_out),
    .data_32_8   (data_32_8),
    .valid_32_8  (valid_32_8),
    .sincout     (sincout)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model state
  int          m_cnt  = 0;
  bit          m_ev   = 1'b0;
  logic [7:0]  m_idle = 8'h00;
  logic [8:0]  byte_q[$];
  logic [31:0] word_q[$];
  logic [31:0] asm_w;
  int          asm_n  = 0;

  always @(posedge clk_4f) begin
    if (reset) begin
      byte_q.delete();
      word_q.delete();
      m_cnt  = 0;
      m_ev   = 1'b0;
      m_idle = 8'h00;
      asm_n  = 0;
    end else if (valid_input && m_cnt == 0) begin
      byte_q.push_back({1'b1, data_input[31:24]});
      byte_q.push_back({1'b0, data_input[23:16]});
      byte_q.push_back({1'b0, data_input[15:8]});
      byte_q.push_back({1'b0, data_input[7:0]});
      word_q.push_back(data_input);
      m_cnt = 3;
      m_ev  = 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_ev = 1'b1;
    end else begin
      m_ev   = 1'b0;
      m_idle = TB_IDLE;
    end
  end

  always @(negedge clk_4f) begin
    logic [8:0] e;
    check("ready_out", 32'(ready_out), 32'(m_cnt == 0 && !reset));
    check("valid_32_8", 32'(valid_32_8), 32'(m_ev));
    if (m_ev && byte_q.size() != 0) begin
      e = byte_q.pop_front();
      check("byte", 32'(data_32_8), 32'(e[7:0]));
      check("sincout", 32'(sincout), 32'(e[8]));
      // Loopback-style reassembly of bytes into words
      if (e[8]) asm_n = 0;
      asm_w = {asm_w[23:0], data_32_8};
      asm_n++;
      if (asm_n == 4 && word_q.size() != 0) begin
        check("word", asm_w, word_q.pop_front());
        asm_n = 0;
      end
    end else if (!m_ev) begin
      check("idle_byte", 32'(data_32_8), 32'(m_idle));
      check("idle_sinc", 32'(sincout), 32'(0));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_4f);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    data_input  = w;
    valid_input = 1'b1;
    step(1);
    valid_input = 1'b0;
    data_input  = $urandom;
  endtask

  // Hold valid high; offer the next word only when the model says a slot is free,
  // and scramble data_input while the block is busy.
  task automatic stream(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input int nw);
    logic [31:0] ws [3];
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    valid_input = 1'b1;
    for (int i = 0; i < nw; i++) begin
      data_input = ws[i];
      step(1);
      for (int k = 0; k < 8 && m_cnt != 0; k++) begin
        data_input = $urandom;
        step(1);
      end
    end
    valid_input = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    valid_input = 1'b0;
    data_input  = 32'h0;
    step(2);
    reset = 1'b0;
    step(4);

    send_word(32'hA1B2C3D4);
    step(6);

    stream(32'h11223344, 32'h55667788, 32'h0, 2);
    step(5);

    stream($urandom, $urandom, $urandom, 3);
    step(3);

    // Reset after B2 is on the output: C3/D4 must never appear
    send_word(32'hA1B2C3D4);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    send_word(32'hCAFEF00D);
    step(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m32_8.md
M32_8 -- requirements
Module: m32_8

Interface
REQ-001 Port clk_4f, input, 1: byte-rate clock; all state changes on its rising edge only.
REQ-002 Port reset, input, 1: synchronous, active-high reset, sampled on rising clk_4f.
REQ-003 Port data_input, input, 32: word to serialize; bits [31:24] are sent first.
REQ-004 Port valid_input, input, 1: data_input is valid this cycle.
REQ-005 Port ready_out, output, 1: block accepts a word this cycle; a transfer occurs when valid_input && ready_out at a rising edge.
REQ-006 Port data_32_8, output, 8: registered serial byte.
REQ-007 Port valid_32_8, output, 1: registered; data_32_8 carries payload.
REQ-008 Port sincout, output, 1: registered; high only with the first byte [31:24] of each word.

Function
REQ-009 States SHALL be IDLE and SEND; a 2-bit counter cnt SHALL hold the number of bytes still to be output after the byte currently on data_32_8.
REQ-010 ready_out SHALL be combinational: (state==IDLE || cnt==0) && !reset.
REQ-011 On a transfer at edge N: data_32_8<=data_input[31:24], valid_32_8<=1, sincout<=1, cnt<=3, state<=SEND, and data_input[23:0] is captured in a 24-bit shift register.
REQ-012 In SEND with cnt!=0 at an edge: data_32_8<=next byte (MSB side of shift register), shift left 8, cnt<=cnt-1, valid_32_8<=1, sincout<=0; valid_input is ignored because ready_out is low.
REQ-013 Bytes [23:16], [15:8] and [7:0] SHALL appear after edges N+1, N+2 and N+3; latency from transfer to first byte is one edge.
REQ-014 In SEND with cnt==0: a transfer SHALL follow REQ-011, giving gapless back-to-back words with sincout every 4th cycle.
REQ-015 In SEND with cnt==0 and no transfer: state<=IDLE, valid_32_8<=0, sincout<=0, data_32_8<=idle byte (REQ-020).
REQ-016 In IDLE with no transfer: the outputs SHALL hold the idle byte with valid_32_8=0 and sincout=0.
REQ-017 data_input SHALL be sampled only on transfer edges; changes at other times SHALL have no effect.

Reset
REQ-018 When reset is high at an edge: state=IDLE, cnt=0, shift register=0, data_32_8=8'h00, valid_32_8=0, sincout=0; ready_out=0 while reset is high.
REQ-019 Reset mid-word SHALL abandon the remaining bytes; no partial word is resumed; ready_out=1 in the first cycle after reset is released.

Configuration
REQ-020 Macro M32_8_IDLE_COM_EN: when defined, the idle byte is 8'hBC (COM); when undefined, the idle byte is 8'h00; payload timing is identical in both cases.

Structure
REQ-021 The COM constant (8'hBC), the IDLE/SEND state encodings and the bytes-per-word constant (4) SHALL live in the shared PHY package/include file used by m8_32.
REQ-022 No sub-module; state machine, counter and shift register are flat in m32_8.

Verification
REQ-023 Reset for 2 cycles, then idle -> data_32_8=8'h00 during reset; afterwards 8'hBC (macro on) or 8'h00 (macro off), valid_32_8=0, ready_out=1.
REQ-024 Single word 32'hA1B2C3D4 -> bytes A1,B2,C3,D4 on four consecutive edges, valid_32_8=1, sincout=1 only with A1, then return to IDLE.
REQ-025 Back-to-back words 32'h11223344 and 32'h55667788 with valid_input held high -> 11,22,33,44,55,66,77,88 with no gap; ready_out high only in the cycle before 11 and before 55; sincout high with 11 and 55.
REQ-026 valid_input held high with changing data during bytes 2-4 -> ignored; only words sampled at ready_out=1 are sent.
REQ-027 Reset asserted after byte B2 of 32'hA1B2C3D4 -> output 8'h00, valid_32_8=0; C3 and D4 never appear; the next word starts cleanly with sincout=1.
REQ-028 Loopback: m32_8 output drives m8_32 (sinc=0) -> m8_32 reproduces the words sent by m32_8, in order.
